// File: rtl/mult_dispatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_dispatch_ctrl_pkg
//   Shared defaults and FSM encoding for the multiplier dispatch front-end.
//   No ports.
// -----------------------------------------------------------------------------
package mult_dispatch_ctrl_pkg;

   localparam int WIDTH_DEF          = 32;
   localparam int TAG_W_DEF          = 4;
   localparam int FIFO_DEPTH_DEF     = 4;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/mult_dispatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_dispatch_ctrl_if
//   Operand request and result response channels of the dispatch front-end.
//   Signals:
//     in_valid / in_ready / in_a / in_b / in_tag      operand request channel
//     out_valid / out_ready / out_product / out_tag / out_err   result channel
//   Modports:
//     master : producer of operands and consumer of results
//     slave  : the dispatch controller
// -----------------------------------------------------------------------------
interface mult_dispatch_ctrl_if
   import mult_dispatch_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAG_W = TAG_W_DEF
);

   logic                      in_valid;
   logic                      in_ready;
   logic signed [WIDTH-1:0]   in_a;
   logic signed [WIDTH-1:0]   in_b;
   logic [TAG_W-1:0]          in_tag;

   logic                      out_valid;
   logic                      out_ready;
   logic signed [2*WIDTH-1:0] out_product;
   logic [TAG_W-1:0]          out_tag;
   logic                      out_err;

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_product, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_product, out_tag, out_err
   );

endinterface

// File: rtl/mult_dispatch_ctrl_operand_fifo.sv
// -----------------------------------------------------------------------------
// mult_operand_fifo
//   Synchronous FIFO holding {tag, b, a} entries. Registered occupancy count;
//   full/empty decoded from the count. Head entry is visible on dout
//   without a read latency so the controller can pop and capture in one edge.
//   Ports:
//     clk, rst       clock, synchronous active-low reset
//     push, din      write request / data (ignored when full)
//     pop, dout      read request (ignored when empty) / head entry
//     count          occupancy 0..DEPTH
//     full, empty    status flags
// -----------------------------------------------------------------------------
module mult_operand_fifo #(
   parameter int DATA_W = 68,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        din,
   input  logic                     pop,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr];

endmodule

// File: rtl/mult_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// mult_dispatch_ctrl
//   Front-end for a sequential multiplier. Queues signed operand pairs with a
//   tag, issues one start pulse per operation, waits for done and returns the
//   2*WIDTH product with its tag. One operation in flight, results in order.
//   Ports:
//     clk, rst        clock, synchronous active-low reset (0 = reset)
//     bus (slave)     operand request / result response channels
//     mul_start       one-cycle start to the multiplier
//     mul_a, mul_b    registered operands to the multiplier
//     mul_product     product from the multiplier
//     mul_done        done level from the multiplier
//     busy            FSM not idle or queue non-empty
//     fifo_count      queue occupancy
//   Build option:
//     MUL_TIMEOUT_EN  enables the WAIT timeout (TIMEOUT_CYCLES); when
//                     undefined WAIT lasts until done and out_err is 0.
// -----------------------------------------------------------------------------
module mult_dispatch_ctrl
   import mult_dispatch_ctrl_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
   parameter int TAG_W          = TAG_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   mult_dispatch_ctrl_if.slave             bus,
   output logic                            mul_start,
   output logic signed [WIDTH-1:0]         mul_a,
   output logic signed [WIDTH-1:0]         mul_b,
   input  logic signed [2*WIDTH-1:0]       mul_product,
   input  logic                            mul_done,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int EW = 2*WIDTH + TAG_W;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
   begin : g_bad_cfg
      $error("mult_dispatch_ctrl: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
   end

   state_t                  state_q;
   state_t                  state_d;
   logic                    push;
   logic                    pop;
   logic                    full;
   logic                    empty;
   logic [EW-1:0]           fifo_din;
   logic [EW-1:0]           fifo_dout;
   logic signed [WIDTH-1:0] head_a;
   logic signed [WIDTH-1:0] head_b;
   logic [TAG_W-1:0]        head_tag;
   logic [TAG_W-1:0]        tag_q;
   logic                    timeout_hit;
   logic                    finish;

   // No pass-through: a full queue refuses even if a pop happens this cycle.
   assign bus.in_ready = !full;
   assign push         = bus.in_valid && !full;
   assign fifo_din     = {bus.in_tag, bus.in_b, bus.in_a};
   assign {head_tag, head_b, head_a} = fifo_dout;

   mult_operand_fifo #(
      .DATA_W (EW),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // ---- FSM state register ----
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // WAIT ends on done, or on timeout when that option is built in.
   assign finish = (state_q == ST_WAIT) && (mul_done || timeout_hit);

   // ---- FSM next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!empty && !bus.out_valid) state_d = ST_ISSUE;
         // done seen here may still belong to the previous operation
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (mul_done || timeout_hit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---- FSM outputs ----
   always_comb begin
      pop       = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE:  pop       = !empty && !bus.out_valid;
         ST_ISSUE: mul_start = 1'b1;
         default:  ;
      endcase
   end

   // Operands held until the next pop so the multiplier may sample at will.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mul_a <= '0;
         mul_b <= '0;
         tag_q <= '0;
      end else if (pop) begin
         mul_a <= head_a;
         mul_b <= head_b;
         tag_q <= head_tag;
      end
   end

   // ---- result register ----
   // Set and clear cannot collide: a new op only starts once out_valid is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.out_valid   <= 1'b0;
         bus.out_product <= '0;
         bus.out_tag     <= '0;
      end else if (finish) begin
         bus.out_valid   <= 1'b1;
         bus.out_product <= mul_done ? mul_product : '0;
         bus.out_tag     <= tag_q;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid   <= 1'b0;
      end
   end

`ifdef MUL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_cnt;

   // Counts completed WAIT cycles; cleared whenever not waiting.
   always_ff @(posedge clk) begin
      if (!rst)                  wait_cnt <= '0;
      else if (state_q != ST_WAIT) wait_cnt <= '0;
      else                       wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   // A done arriving on the final cycle wins over the abort.
   always_ff @(posedge clk) begin
      if (!rst)                              bus.out_err <= 1'b0;
      else if (finish)                       bus.out_err <= !mul_done;
      else if (bus.out_valid && bus.out_ready) bus.out_err <= 1'b0;
   end
`else
   assign timeout_hit = 1'b0;
   assign bus.out_err = 1'b0;
`endif

   assign busy = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_mult_dispatch_ctrl.sv
module tb_mult_dispatch_ctrl;

   localparam int WIDTH          = 32;
   localparam int TAG_W          = 4;
   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 16;

   typedef struct packed {
      logic [63:0]      product;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mult_dispatch_ctrl_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   logic                     mul_start;
   logic signed [WIDTH-1:0]  mul_a;
   logic signed [WIDTH-1:0]  mul_b;
   logic signed [63:0]       mul_product;
   logic                     mul_done;
   logic                     busy;
   logic [2:0]               fifo_count;

   mult_dispatch_ctrl #(
      .WIDTH          (WIDTH),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TAG_W          (TAG_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mul_done    (mul_done),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   // Behavioural multiplier: variable latency, done is a level held until
   // the next start is sampled; reset from the inverted controller reset.
   int                 lat = 3;
   bit                 never_done = 1'b0;
   int                 mcnt;
   logic signed [63:0] mpend;

   always @(posedge clk) begin
      if (!rst) begin
         mul_done    <= 1'b0;
         mul_product <= '0;
         mcnt        <= 0;
      end else if (mul_start) begin
         mul_done <= 1'b0;
         mcnt     <= lat;
         mpend    <= mul_a * mul_b;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && !never_done) begin
            mul_done    <= 1'b1;
            mul_product <= mpend;
         end
      end
   end

   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_out  = 0;
   int   starts = 0;
   exp_t expq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst && mul_start) starts++;
   end

   // Monitor: every accepted result is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result actual product=%h tag=%0d required none",
                     bus.out_product, bus.out_tag);
         end else begin
            e = expq.pop_front();
            chk($sformatf("product_tag%0d", e.tag), bus.out_product, e.product);
            chk($sformatf("tag_tag%0d", e.tag), 64'(bus.out_tag), 64'(e.tag));
            chk($sformatf("err_tag%0d", e.tag), 64'(bus.out_err), 64'(e.err));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic push(input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [63:0] prod,
                       input bit err, input bit expect_it);
      int guard;
      guard      = 0;
      bus.in_a   = a;
      bus.in_b   = b;
      bus.in_tag = tag;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL push_timeout tag=%0d actual in_ready=0 required 1", tag);
      end else if (expect_it) begin
         expq.push_back(exp_t'{prod, tag, err});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || bus.out_valid || expq.size() != 0) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout actual busy=%0d pending=%0d required 0", busy, expq.size());
      end
      @(posedge clk);
      #1;
   endtask

   logic signed [31:0] ta [6] = '{32'sd3, -32'sd4, 32'sd100, -32'sd1, 32'sh7FFF_FFFF, -32'sd7};
   logic signed [31:0] tb [6] = '{32'sd5, 32'sd6, -32'sd3, -32'sd1, -32'sd1, -32'sd9};
   logic [63:0]        tp [6] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFE8,
                                  64'hFFFF_FFFF_FFFF_FED4, 64'h0000_0000_0000_0001,
                                  64'hFFFF_FFFF_8000_0001, 64'h0000_0000_0000_003F};

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog actual=expired required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int o0;
      bit stable;
      logic [63:0] snap_p;
      logic [TAG_W-1:0] snap_t;
      int guard;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      rst           = 1'b0;

      // Reset, with a push attempted that must be ignored
      cycles(1);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'sd9;
      bus.in_b     = 32'sd9;
      cycles(3);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_err", 64'(bus.out_err), 64'd0);
      chk("rst_out_product", bus.out_product, 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_mul_a", 64'($unsigned(mul_a)), 64'd0);
      chk("rst_mul_b", 64'($unsigned(mul_b)), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      cycles(2);

      // 10 x -5, single op, latency from push to start
      s0 = starts;
      push(32'sd10, -32'sd5, 4'd3, 64'hFFFF_FFFF_FFFF_FFCE, 1'b0, 1'b1);
      chk("t1_no_early_start", 64'(mul_start), 64'd0);
      @(posedge clk);
      #1;
      chk("t1_start_after_push", 64'(mul_start), 64'd1);
      chk("t1_mul_a", 64'($unsigned(mul_a)), 64'h0000_0000_0000_000A);
      chk("t1_mul_b", 64'($unsigned(mul_b)), 64'h0000_0000_FFFF_FFFB);
      @(posedge clk);
      #1;
      chk("t1_start_one_cycle", 64'(mul_start), 64'd0);
      wait_idle();
      chk("t1_start_count", 64'(starts - s0), 64'd1);

      // Signed extremes and sign corners at varied latency
      lat = 1;
      push(32'sh8000_0000, 32'sh8000_0000, 4'd1, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
      lat = 7;
      push(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 4'd2, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b1);
      lat = 2;
      push(32'sd0, -32'sd7, 4'd4, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
      push(-32'sd1, 32'sd1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      push(32'sh8000_0000, 32'sd1, 4'd6, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
      wait_idle();

      // Back-to-back pushes with a stalled consumer, then a long hold
      lat = 3;
      s0  = starts;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               push(ta[i], tb[i], TAG_W'(i), tp[i], 1'b0, 1'b1);
         end
         begin
            guard = 0;
            @(negedge clk);
            while (bus.in_ready && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            chk("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("t3_count_full", 64'(fifo_count), 64'd4);
            guard = 0;
            while (!bus.out_valid && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            chk("t3_out_slot_held", 64'(bus.out_valid), 64'd1);
            snap_p = bus.out_product;
            snap_t = bus.out_tag;
            o0     = starts;
            stable = 1'b1;
            repeat (50) begin
               @(negedge clk);
               if (!bus.out_valid || bus.out_product !== snap_p ||
                   bus.out_tag !== snap_t || bus.in_ready)
                  stable = 1'b0;
            end
            chk("t4_hold_stable", 64'(stable), 64'd1);
            chk("t4_hold_product", snap_p, tp[0]);
            chk("t4_no_extra_start", 64'(starts - o0), 64'd0);
            chk("t4_count_held", 64'(fifo_count), 64'd4);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("t3_start_count", 64'(starts - s0), 64'd6);

      // Reset while an op is in WAIT and another is queued
      lat = 20;
      o0  = n_out;
      push(32'sd9, 32'sd9, 4'd7, 64'd81, 1'b0, 1'b0);
      push(32'sd2, 32'sd2, 4'd8, 64'd4, 1'b0, 1'b0);
      cycles(4);
      chk("t5_busy_before", 64'(busy), 64'd1);
      chk("t5_count_before", 64'(fifo_count), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
      chk("t5_fifo_count", 64'(fifo_count), 64'd0);
      chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);
      cycles(40);
      chk("t5_no_aborted_result", 64'(n_out - o0), 64'd0);
      lat = 2;
      push(-32'sd3, 32'sd7, 4'd9, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
      wait_idle();

`ifdef MUL_TIMEOUT_EN
      // Timeout abort when done never arrives, then a normal op
      never_done    = 1'b1;
      bus.out_ready = 1'b0;
      push(32'sd5, 32'sd5, 4'd10, 64'd0, 1'b1, 1'b1);
      repeat (17) @(posedge clk);
      #1;
      chk("t6_not_yet_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("t6_timeout_valid", 64'(bus.out_valid), 64'd1);
      chk("t6_timeout_err", 64'(bus.out_err), 64'd1);
      bus.out_ready = 1'b1;
      wait_idle();
      never_done = 1'b0;
      push(32'sd6, 32'sd7, 4'd11, 64'd42, 1'b0, 1'b1);
      wait_idle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
